sat_accum: RTL and testbench

SAT_ACCUM -- requirements
Module: sat_accum

---
 rtl/sat_accum.sv | 114 +++++++++++
 tb/tb_sat_accum.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/sat_accum.sv
// sat_accum: 32-bit saturating accumulator, bit-serial in SLICE_W slices; optional `SAT_ACCUM_CNT_EN adds sat_count.
// Latency: result valid N+2 edges after accept counting the accept edge (N = 32/SLICE_W cycles CALC + 1 SAT).
// Backpressure: in_ready only in IDLE; OUT holds out_acc/flags until out_valid && out_ready.
module sat_accum #(
    parameter int SLICE_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_sub,
    input  logic        in_clear,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_acc,
    output logic        out_pos_sat,
    output logic        out_neg_sat
`ifdef SAT_ACCUM_CNT_EN
    ,
    output logic [15:0] sat_count
`endif
);
    localparam int N     = 32 / SLICE_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CALC, SAT, OUT} state_t;

    state_t             state;
    logic [31:0]        a_sh;
    logic [31:0]        b_sh;
    logic [31:0]        sum;
    logic               a_msb;
    logic               b_msb;
    logic               carry;
    logic [CNT_W-1:0]   slice;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;
    logic               pos_ovf;
    logic               neg_ovf;

    // Operands shift right one slice per cycle; the sum fills in from the top.
    always_comb begin
        {slice_cout, slice_sum} = {1'b0, a_sh[SLICE_W-1:0]} + {1'b0, b_sh[SLICE_W-1:0]}
                                + (SLICE_W+1)'(carry);
    end

    // Sign bits of the effective operands are kept aside since the shifters lose them.
    assign pos_ovf   = !a_msb && !b_msb &&  sum[31];
    assign neg_ovf   =  a_msb &&  b_msb && !sum[31];
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_sh        <= '0;
            b_sh        <= '0;
            sum         <= '0;
            a_msb       <= 1'b0;
            b_msb       <= 1'b0;
            carry       <= 1'b0;
            slice       <= '0;
            out_acc     <= '0;
            out_pos_sat <= 1'b0;
            out_neg_sat <= 1'b0;
`ifdef SAT_ACCUM_CNT_EN
            sat_count   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= in_clear ? 32'h0 : out_acc;
                        a_msb <= in_clear ? 1'b0 : out_acc[31];
                        b_sh  <= in_sub ? ~in_data : in_data;
                        b_msb <= in_sub ? ~in_data[31] : in_data[31];
                        carry <= in_sub;
                        sum   <= '0;
                        slice <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    sum   <= (sum >> SLICE_W) | (32'(slice_sum) << (32 - SLICE_W));
                    carry <= slice_cout;
                    a_sh  <= a_sh >> SLICE_W;
                    b_sh  <= b_sh >> SLICE_W;
                    slice <= slice + 1'b1;
                    if (slice == CNT_W'(N - 1)) begin
                        state <= SAT;
                    end
                end
                SAT: begin
                    out_acc     <= pos_ovf ? 32'h7FFF_FFFF : (neg_ovf ? 32'h8000_0000 : sum);
                    out_pos_sat <= pos_ovf;
                    out_neg_sat <= neg_ovf;
`ifdef SAT_ACCUM_CNT_EN
                    if ((pos_ovf || neg_ovf) && sat_count != 16'hFFFF) begin
                        sat_count <= sat_count + 16'd1;
                    end
`endif
                    state <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sat_accum.sv
// Directed bench for sat_accum (SLICE_W=8); outputs sampled 1 time unit after the rising edge.
module tb_sat_accum;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_sub;
    logic        in_clear;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_acc;
    logic        out_pos_sat;
    logic        out_neg_sat;
`ifdef SAT_ACCUM_CNT_EN
    logic [15:0] sat_count;
`endif

    int tests  = 0;
    int failed = 0;
    int lat;
    logic [31:0] held;

    always #5 clk = ~clk;

    sat_accum #(.SLICE_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sub(in_sub), .in_clear(in_clear),
        .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
        .out_pos_sat(out_pos_sat), .out_neg_sat(out_neg_sat)
`ifdef SAT_ACCUM_CNT_EN
        , .sat_count(sat_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Offer an operand, take the accept edge, then count edges until out_valid.
    task automatic op(input logic [31:0] d, input logic s, input logic c, output int edges);
        in_data  = d;
        in_sub   = s;
        in_clear = c;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        edges = 0;
        while (!out_valid && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic chk_res(input string tag, input logic [31:0] acc, input logic p, input logic n);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_acc"}, out_acc, acc);
        chk({tag, "_pos"}, 32'(out_pos_sat), 32'(p));
        chk({tag, "_neg"}, 32'(out_neg_sat), 32'(n));
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sub = 1'b0; in_clear = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_acc", out_acc, 32'h0);
        chk("rst_flags", {30'd0, out_pos_sat, out_neg_sat}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Clear-load 1: the accept edge plus five more edges makes out_valid appear on the sixth edge.
        op(32'h1, 1'b0, 1'b1, lat);
        chk("first_latency", 32'(lat), 32'd5);
        chk_res("load1", 32'h0000_0001, 1'b0, 1'b0);
        consume();
        chk("idle_after_hs", 32'(in_ready), 32'd1);

        op(32'h7FFF_FFFF, 1'b0, 1'b1, lat);
        chk_res("load_max", 32'h7FFF_FFFF, 1'b0, 1'b0);
        consume();
        op(32'h1, 1'b0, 1'b0, lat);
        chk_res("pos_sat", 32'h7FFF_FFFF, 1'b1, 1'b0);
        consume();

        op(32'h8000_0000, 1'b0, 1'b1, lat);
        chk_res("load_min", 32'h8000_0000, 1'b0, 1'b0);
        consume();
        op(32'h1, 1'b1, 1'b0, lat);
        chk_res("neg_sat", 32'h8000_0000, 1'b0, 1'b1);
        consume();
        op(32'h8000_0000, 1'b1, 1'b1, lat);
        chk_res("neg_min_sat", 32'h7FFF_FFFF, 1'b1, 1'b0);
`ifdef SAT_ACCUM_CNT_EN
        chk("sat_count3", 32'(sat_count), 32'd3);
`endif
        consume();

        op(32'h0000_9644, 1'b0, 1'b1, lat);
        consume();
        op(32'h0001_85EF, 1'b1, 1'b0, lat);
        chk_res("sub_cross", 32'hFFFF_1055, 1'b0, 1'b0);
        held = out_acc;
        // Stall the consumer and offer a stray operand; neither may disturb OUT.
        in_valid = 1'b1; in_data = 32'h1234_5678; in_sub = 1'b0; in_clear = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_acc", out_acc, held);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        consume();

        // Carry has to ripple through every slice to reach zero.
        op(32'h0000_EFAB, 1'b0, 1'b0, lat);
        chk_res("carry_ripple", 32'h0000_0000, 1'b0, 1'b0);
        consume();

        op(32'h7FFF_FFFF, 1'b0, 1'b1, lat);
        consume();
        op(32'h1, 1'b0, 1'b0, lat);
        chk_res("pre_rst_sat", 32'h7FFF_FFFF, 1'b1, 1'b0);
        consume();

        // Reset during the second CALC cycle.
        in_data = 32'h5; in_sub = 1'b0; in_clear = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_acc", out_acc, 32'h0);
        chk("midrst_pos", 32'(out_pos_sat), 32'd0);
`ifdef SAT_ACCUM_CNT_EN
        chk("midrst_sat_count", 32'(sat_count), 32'd0);
`endif
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_no_resume", 32'(out_valid), 32'd0);

        op(32'h3, 1'b0, 1'b0, lat);
        chk_res("post_rst_add", 32'h0000_0003, 1'b0, 1'b0);
        consume();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
